// File: rtl/alu_pwr_ctrl.sv
// Sequences power, isolation, save and restore for the switchable ALU domain; all outputs registered with the state.
// Requests are acted on only in RUN/OFF; in-flight sequences always complete, and sleep waits for the ALU to go idle.
module alu_pwr_ctrl #(
  parameter int PWR_UP_CYCLES = 4,
  parameter int SAVE_TIMEOUT  = 8,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sleep_req,
  input  logic       wake_req,
  input  logic       alu_busy,
  input  logic       alu_result_valid,
  output logic       alu_pwr_en,
  output logic       iso_en,
  output logic       save,
  output logic       restore,
  output logic       pd_off,
  output logic       sleep_done,
  output logic       wake_done,
  output logic       save_err,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_RUN     = 3'd0,
    S_SAVE    = 3'd1,
    S_ISO     = 3'd2,
    S_OFF     = 3'd3,
    S_PWRUP   = 3'd4,
    S_RESTORE = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] SAVE_LAST  = CNT_W'(SAVE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWR_UP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             alu_pwr_en_q, alu_pwr_en_d;
  logic             iso_en_q, iso_en_d;
  logic             save_q, save_d;
  logic             restore_q, restore_d;
  logic             pd_off_q, pd_off_d;
  logic             sleep_done_q, sleep_done_d;
  logic             wake_done_q, wake_done_d;
  logic             save_err_q, save_err_d;

  always_comb begin
    state_d    = state_q;
    save_err_d = save_err_q;
    case (state_q)
      S_RUN:     if (sleep_req && !wake_req && !alu_busy) state_d = S_SAVE;
      S_SAVE: begin
        if (alu_result_valid) begin
          state_d = S_ISO;
        end else if (cnt_q == SAVE_LAST) begin
          state_d    = S_ISO;
          save_err_d = 1'b1;
        end
      end
      S_ISO:     state_d = S_OFF;
      S_OFF:     if (wake_req) state_d = S_PWRUP;
      S_PWRUP:   if (cnt_q == PWRUP_LAST) state_d = S_RESTORE;
      S_RESTORE: state_d = S_RUN;
      default:   state_d = S_RUN;
    endcase

    // One shared counter: cleared on every state change, so it times SAVE and PWRUP from entry.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    alu_pwr_en_d = 1'b1;
    iso_en_d     = 1'b0;
    save_d       = 1'b0;
    restore_d    = 1'b0;
    pd_off_d     = 1'b0;
    case (state_d)
      S_SAVE:    save_d = 1'b1;
      S_ISO:     iso_en_d = 1'b1;
      S_OFF: begin
        alu_pwr_en_d = 1'b0;
        iso_en_d     = 1'b1;
        pd_off_d     = 1'b1;
      end
      S_PWRUP:   iso_en_d = 1'b1;
      S_RESTORE: restore_d = 1'b1;
      default:   ;
    endcase

    sleep_done_d = (state_q == S_ISO) && (state_d == S_OFF);
    wake_done_d  = (state_q == S_RESTORE) && (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_RUN;
      cnt_q        <= '0;
      alu_pwr_en_q <= 1'b1;
      iso_en_q     <= 1'b0;
      save_q       <= 1'b0;
      restore_q    <= 1'b0;
      pd_off_q     <= 1'b0;
      sleep_done_q <= 1'b0;
      wake_done_q  <= 1'b0;
      save_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_pwr_en_q <= alu_pwr_en_d;
      iso_en_q     <= iso_en_d;
      save_q       <= save_d;
      restore_q    <= restore_d;
      pd_off_q     <= pd_off_d;
      sleep_done_q <= sleep_done_d;
      wake_done_q  <= wake_done_d;
      save_err_q   <= save_err_d;
    end
  end

  assign alu_pwr_en = alu_pwr_en_q;
  assign iso_en     = iso_en_q;
  assign save       = save_q;
  assign restore    = restore_q;
  assign pd_off     = pd_off_q;
  assign sleep_done = sleep_done_q;
  assign wake_done  = wake_done_q;
  assign save_err   = save_err_q;
  assign state      = state_q;

endmodule

// File: tb/tb_alu_pwr_ctrl.sv
// Directed and random sequences for alu_pwr_ctrl, checked against a phase/duration model of the power sequence.
module tb_alu_pwr_ctrl;
  localparam int PWR_UP = 4;
  localparam int TMO    = 8;

  localparam int P_RUN = 0, P_SAVE = 1, P_ISO = 2, P_OFF = 3, P_PWRUP = 4, P_RESTORE = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sleep_req = 1'b0, wake_req = 1'b0, alu_busy = 1'b0, alu_result_valid = 1'b0;
  logic       alu_pwr_en, iso_en, save, restore, pd_off, sleep_done, wake_done, save_err;
  logic [2:0] state;

  alu_pwr_ctrl #(.PWR_UP_CYCLES(PWR_UP), .SAVE_TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .sleep_req(sleep_req), .wake_req(wake_req),
    .alu_busy(alu_busy), .alu_result_valid(alu_result_valid),
    .alu_pwr_en(alu_pwr_en), .iso_en(iso_en), .save(save), .restore(restore),
    .pd_off(pd_off), .sleep_done(sleep_done), .wake_done(wake_done),
    .save_err(save_err), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected {pwr, iso, save, restore, pd_off} for each phase.
  logic [4:0] out_tbl [6] = '{5'b10000, 5'b10100, 5'b11000, 5'b01001, 5'b11000, 5'b10010};

  int   ph;
  int   left;
  bit   m_err, m_sd, m_wd;
  logic prev_iso;
  logic [2:0] prev_state;
  int   save_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ph = P_RUN; left = 0; m_err = 0; m_sd = 0; m_wd = 0;
  endtask

  task automatic model_step(input bit s, input bit w, input bit b, input bit v);
    int prev;
    prev = ph;
    case (ph)
      P_RUN:   if (s && !w && !b) begin ph = P_SAVE; left = TMO; end
      P_SAVE: begin
        if (v) ph = P_ISO;
        else if (left == 1) begin ph = P_ISO; m_err = 1; end
        else left--;
      end
      P_ISO:   ph = P_OFF;
      P_OFF:   if (w) begin ph = P_PWRUP; left = PWR_UP; end
      P_PWRUP: if (left == 1) ph = P_RESTORE; else left--;
      default: ph = P_RUN;
    endcase
    m_sd = (ph == P_OFF) && (prev != P_OFF);
    m_wd = (ph == P_RUN) && (prev == P_RESTORE);
  endtask

  task automatic check_all(input string tag);
    logic [4:0] e;
    e = out_tbl[ph];
    chk({tag, ".state"},      32'(state),      32'(ph));
    chk({tag, ".pwr"},        32'(alu_pwr_en), 32'(e[4]));
    chk({tag, ".iso"},        32'(iso_en),     32'(e[3]));
    chk({tag, ".save"},       32'(save),       32'(e[2]));
    chk({tag, ".restore"},    32'(restore),    32'(e[1]));
    chk({tag, ".pd_off"},     32'(pd_off),     32'(e[0]));
    chk({tag, ".sleep_done"}, 32'(sleep_done), 32'(m_sd));
    chk({tag, ".wake_done"},  32'(wake_done),  32'(m_wd));
    chk({tag, ".save_err"},   32'(save_err),   32'(m_err));
    chk({tag, ".inv_pwr_iso"},  32'(alu_pwr_en | iso_en), 32'd1);
    chk({tag, ".inv_save_rst"}, 32'(save & restore),      32'd0);
    chk({tag, ".inv_save_iso"}, 32'(save & iso_en),       32'd0);
    if (prev_iso === 1'b1 && iso_en === 1'b0)
      chk({tag, ".inv_iso_fall"}, 32'(prev_state), 32'(P_PWRUP));
    prev_iso   = iso_en;
    prev_state = state;
  endtask

  // Called just after a posedge (or at a negedge): drive, clock once, check.
  task automatic cyc(input string tag, input bit s, input bit w, input bit b, input bit v);
    sleep_req = s; wake_req = w; alu_busy = b; alu_result_valid = v;
    @(posedge clk);
    model_step(s, w, b, v);
    #1;
    check_all(tag);
    if (save === 1'b1) save_cnt++;
  endtask

  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    prev_iso = 1'b0;
    check_all({tag, ".async"});
    @(posedge clk);
    #1;
    check_all({tag, ".hold"});
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    prev_iso   = 1'b0;
    prev_state = 3'd0;
    save_cnt   = 0;
    @(posedge clk);
    #1;
    check_all("rst0");
    @(negedge clk);
    rst_n = 1'b1;

    cyc("idle", 0, 0, 0, 0);
    cyc("idle", 0, 0, 0, 0);

    // Sleep with a valid result on the first SAVE cycle: OFF three edges after the request.
    cyc("slp_req",  1, 0, 0, 0);
    cyc("slp_save", 1, 0, 0, 1);
    cyc("slp_iso",  1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("off_hold", 1, 0, 0, 0);
    chk("off_reached", 32'(pd_off), 32'd1);

    // Wake: PWRUP x4, RESTORE, RUN on the sixth edge.
    for (int i = 0; i < 6; i++) cyc("wake", 0, 1, 0, 0);
    chk("wake_in_run", 32'(state), 32'(P_RUN));
    cyc("run", 0, 0, 0, 0);

    // Busy holds off sleep, then a save that times out.
    for (int i = 0; i < 5; i++) cyc("busy", 1, 0, 1, 0);
    save_cnt = 0;
    cyc("busy_drop", 1, 0, 0, 0);
    for (int i = 0; i < 12; i++) cyc("timeout", 0, 0, 0, 0);
    chk("save_len", 32'(save_cnt), 32'(TMO));
    chk("save_err_set", 32'(save_err), 32'd1);
    for (int i = 0; i < 6; i++) cyc("wake2", 0, 1, 0, 0);
    for (int i = 0; i < 2; i++) cyc("both_run", 1, 1, 0, 0);
    chk("save_err_sticky", 32'(save_err), 32'd1);

    // Reset during PWRUP.
    for (int i = 0; i < 3; i++) cyc("slp3", 1, 0, 0, 1);
    for (int i = 0; i < 2; i++) cyc("pwrup", 0, 1, 0, 0);
    do_reset("rst_pwrup");

    // Reset with both requests high: no sleep sequence afterwards.
    sleep_req = 1'b1; wake_req = 1'b1;
    do_reset("rst_both");
    for (int i = 0; i < 3; i++) cyc("both_post", 1, 1, 0, 0);

    // Random traffic with occasional asynchronous reset.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 96) == 0) do_reset("rnd_rst");
      else cyc("rnd", ($urandom % 4) != 0, ($urandom % 5) == 0,
               ($urandom % 3) == 0, ($urandom % 6) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
